ps2_host: RTL and testbench

Host-side PS/2 protocol engine that sits directly behind the PS/2 pad driver. It consumes the synchronized pad samples (`ps2_clk_d`, `ps2_data_d`) and produces the active-high pull-low requests (`ps2_clk_q`, `ps2_data_q`). It deframes device-to-host scan-code frames and serializes host-to-device command bytes using the standard 11-bit frame: start, 8 data LSB-first, odd parity, stop. Its byte-level ports feed the keyboard/mouse logic of the programmer front end.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_host_if.sv | 24 ++
 rtl/ps2_clk_filter.sv | 39 +++
 rtl/ps2_host.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_host.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host engine.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX,
    TX_INHIBIT,
    TX_DATA,
    TX_ACK,
    TX_WAIT
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_if.sv
// Byte-level receive/transmit handshake between the PS/2 engine and its client.
interface ps2_host_if;
  import ps2_pkg::*;

  logic [PS2_DATA_BITS-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_err;
  logic [PS2_DATA_BITS-1:0] tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     tx_done;
  logic                     tx_err;

  modport master (
    input  rx_data, rx_valid, rx_err, tx_ready, tx_done, tx_err,
    output tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, rx_err, tx_ready, tx_done, tx_err,
    input  tx_data, tx_valid
  );

endinterface

// File: rtl/ps2_clk_filter.sv
// 4-sample glitch filter for the PS/2 clock; data is delayed to stay aligned.
module ps2_clk_filter (
  input  logic clk,
  input  logic rst,
  input  logic clk_raw,
  input  logic data_raw,
  output logic clk_filt,
  output logic data_dly
);

  logic [2:0] clk_hist;
  logic [2:0] data_hist;
  logic       filt_q;

  // The level flips only when the three previous samples and the current one agree.
  always_comb begin
    clk_filt = filt_q;
    if (clk_hist == 3'b000 && !clk_raw) begin
      clk_filt = 1'b0;
    end else if (clk_hist == 3'b111 && clk_raw) begin
      clk_filt = 1'b1;
    end
  end

  assign data_dly = data_hist[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_hist  <= 3'b111;
      data_hist <= 3'b111;
      filt_q    <= 1'b1;
    end else begin
      clk_hist  <= {clk_hist[1:0], clk_raw};
      data_hist <= {data_hist[1:0], data_raw};
      filt_q    <= clk_filt;
    end
  end

endmodule

// File: rtl/ps2_host.sv
// Host-side PS/2 frame engine: deframes device bytes and serializes host commands.
// Define PS2_HOST_FILTER_EN to debounce the pad clock before edge detection.
module ps2_host
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_d,
  input  logic ps2_data_d,
  output logic ps2_clk_q,
  output logic ps2_data_q,
  ps2_host_if.slave bus
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam int RX_BITS    = PS2_FRAME_BITS - 1;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT     = 4'(PS2_FRAME_BITS - 2);

  logic clk_now;
  logic data_now;

`ifdef PS2_HOST_FILTER_EN
  ps2_clk_filter u_filter (
    .clk      (clk),
    .rst      (rst),
    .clk_raw  (ps2_clk_d),
    .data_raw (ps2_data_d),
    .clk_filt (clk_now),
    .data_dly (data_now)
  );
`else
  assign clk_now  = ps2_clk_d;
  assign data_now = ps2_data_d;
`endif

  ps2_state_t                 state, state_n;
  logic                       clk_prev;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [3:0]                 bit_cnt, bit_cnt_n;
  logic [RX_BITS-1:0]         rx_shift, rx_shift_n;
  logic [RX_BITS-1:0]         tx_frame, tx_frame_n;
  logic [PS2_DATA_BITS-1:0]   rx_data_r, rx_data_n;
  logic                       rx_valid_r, rx_valid_n;
  logic                       rx_err_r, rx_err_n;
  logic                       tx_done_r, tx_done_n;
  logic                       tx_err_r, tx_err_n;
  logic                       data_q_r, data_q_n;
  logic                       fall;
  logic                       tx_ready;

  assign fall     = clk_prev & ~clk_now;
  assign tx_ready = (state == IDLE) && !rst;

  assign ps2_clk_q  = (state == TX_INHIBIT);
  assign ps2_data_q = data_q_r | ((state == TX_INHIBIT) && (cnt == INHIBIT_LAST));

  assign bus.tx_ready = tx_ready;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_err   = rx_err_r;
  assign bus.tx_done  = tx_done_r;
  assign bus.tx_err   = tx_err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clk_prev   <= 1'b0;
      cnt        <= '0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_frame   <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      tx_done_r  <= 1'b0;
      tx_err_r   <= 1'b0;
      data_q_r   <= 1'b0;
    end else begin
      state      <= state_n;
      clk_prev   <= clk_now;
      cnt        <= cnt_n;
      bit_cnt    <= bit_cnt_n;
      rx_shift   <= rx_shift_n;
      tx_frame   <= tx_frame_n;
      rx_data_r  <= rx_data_n;
      rx_valid_r <= rx_valid_n;
      rx_err_r   <= rx_err_n;
      tx_done_r  <= tx_done_n;
      tx_err_r   <= tx_err_n;
      data_q_r   <= data_q_n;
    end
  end

  // tx_frame holds {stop, parity, data} and shifts in ones, so edge 10 drives a release.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    rx_shift_n = rx_shift;
    tx_frame_n = tx_frame;
    rx_data_n  = rx_data_r;
    data_q_n   = data_q_r;
    rx_valid_n = 1'b0;
    rx_err_n   = 1'b0;
    tx_done_n  = 1'b0;
    tx_err_n   = 1'b0;

    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (fall && !data_now) begin
          rx_shift_n = '0;
          state_n    = RX;
        end else if (bus.tx_valid && tx_ready) begin
          tx_frame_n = {1'b1, ps2_odd_parity(bus.tx_data), bus.tx_data};
          state_n    = TX_INHIBIT;
        end
      end

      RX: begin
        if (fall) begin
          rx_shift_n = {data_now, rx_shift[RX_BITS-1:1]};
          bit_cnt_n  = bit_cnt + 4'd1;
          cnt_n      = '0;
          if (bit_cnt == LAST_BIT) begin
            state_n = IDLE;
            if (rx_shift_n[RX_BITS-1] && (^rx_shift_n[PS2_DATA_BITS:0])) begin
              rx_data_n  = rx_shift_n[PS2_DATA_BITS-1:0];
              rx_valid_n = 1'b1;
            end else begin
              rx_err_n = 1'b1;
            end
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_n  = IDLE;
          rx_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      TX_INHIBIT: begin
        if (cnt == INHIBIT_LAST) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          data_q_n  = 1'b1;
          state_n   = TX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      TX_DATA: begin
        if (fall) begin
          data_q_n   = ~tx_frame[0];
          tx_frame_n = {1'b1, tx_frame[RX_BITS-1:1]};
          bit_cnt_n  = bit_cnt + 4'd1;
          cnt_n      = '0;
          if (bit_cnt == LAST_BIT) begin
            state_n = TX_ACK;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_n  = IDLE;
          tx_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      TX_ACK: begin
        if (fall) begin
          cnt_n = '0;
          if (!data_now) begin
            state_n = TX_WAIT;
          end else begin
            state_n  = IDLE;
            tx_err_n = 1'b1;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          state_n  = IDLE;
          tx_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      TX_WAIT: begin
        if (clk_now && data_now) begin
          state_n   = IDLE;
          tx_done_n = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n  = IDLE;
          tx_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase

    if (state_n == IDLE) begin
      data_q_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host.sv
// Self-checking bench for ps2_host with an open-drain PS/2 device model and scoreboard queues.
module tb_ps2_host;
  import ps2_pkg::*;

  localparam int INH  = 5000;
  localparam int TMO  = 2000;
  localparam int HALF = 20;
`ifdef PS2_HOST_FILTER_EN
  localparam int FILT_LAT = 3;
`else
  localparam int FILT_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_d, ps2_data_d, ps2_clk_q, ps2_data_q;

  ps2_host_if bus ();

  // Open-drain bus: the line is low if either side pulls it.
  assign ps2_clk_d  = dev_clk & ~ps2_clk_q;
  assign ps2_data_d = dev_data & ~ps2_data_q;

  ps2_host #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_d  (ps2_clk_d),
    .ps2_data_d (ps2_data_d),
    .ps2_clk_q  (ps2_clk_q),
    .ps2_data_q (ps2_data_q),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int n_rx_valid = 0, n_rx_err = 0, n_tx_done = 0, n_tx_err = 0;
  logic [7:0] obs_rx[$];
  logic [7:0] exp_rx[$];
  logic       exp_bits[$];
  logic       dev_bits[$];
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      n_rx_valid <= n_rx_valid + 1;
      obs_rx.push_back(bus.rx_data);
    end
    if (bus.rx_err)  n_rx_err  <= n_rx_err + 1;
    if (bus.tx_done) n_tx_done <= n_tx_done + 1;
    if (bus.tx_err)  n_tx_err  <= n_tx_err + 1;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic parity);
    return {1'b1, parity, d, 1'b0};
  endfunction

  function automatic logic good_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Device-to-host: set data while clock high, then pulse the clock low.
  task automatic dev_send(input logic [10:0] bits, input int nbits, output int last_fall);
    last_fall = 0;
    for (int i = 0; i < nbits; i++) begin
      dev_data = bits[i];
      wait_cycles(HALF);
      dev_clk = 1'b0;
      last_fall = cyc;
      wait_cycles(HALF);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    wait_cycles(HALF);
  endtask

  // Host-to-device: measure the inhibit, sample data on each rising edge, then ACK or not.
  task automatic dev_recv(input logic ack, output int inhibit_len);
    int guard;
    guard = 0;
    inhibit_len = 0;
    while (ps2_clk_q !== 1'b1 && guard < 50) begin
      wait_cycles(1);
      guard++;
    end
    while (ps2_clk_q === 1'b1 && inhibit_len < INH + 100) begin
      inhibit_len++;
      wait_cycles(1);
    end
    wait_cycles(HALF);
    dev_bits.push_back(ps2_data_d);
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      wait_cycles(HALF);
      dev_clk = 1'b1;
      dev_bits.push_back(ps2_data_d);
      wait_cycles(HALF);
    end
    dev_data = ack ? 1'b0 : 1'b1;
    dev_clk = 1'b0;
    wait_cycles(HALF);
    dev_clk = 1'b1;
    wait_cycles(HALF);
    dev_data = 1'b1;
  endtask

  task automatic push_tx_bits(input logic [7:0] d);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(good_parity(d));
    exp_bits.push_back(1'b1);
  endtask

  task automatic start_tx(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    wait_cycles(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(3);
    checks++;
    if ({ps2_clk_q, ps2_data_q} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_lines: got %b expected 00", {ps2_clk_q, ps2_data_q});
    end
    checks++;
    if ({bus.rx_valid, bus.rx_err, bus.tx_done, bus.tx_err, bus.tx_ready} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000",
               {bus.rx_valid, bus.rx_err, bus.tx_done, bus.tx_err, bus.tx_ready});
    end
    checks++;
    if (bus.rx_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_rx_data: got %h expected 00", bus.rx_data);
    end
    rst = 1'b0;
    wait_cycles(1);
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", bus.tx_ready);
    end
  endtask

  task automatic test_rx_good();
    int v0, e0, lf;
    logic [7:0] exp_b;
    v0 = n_rx_valid;
    e0 = n_rx_err;
    exp_rx.push_back(8'h1C);
    dev_send(make_frame(8'h1C, 1'b0), 11, lf);
    wait_cycles(5);
    checks++;
    if (n_rx_valid - v0 !== 1) begin
      failures++;
      $display("[TB] FAIL rx_good_valid_count: got %0d expected 1", n_rx_valid - v0);
    end
    checks++;
    if (n_rx_err - e0 !== 0) begin
      failures++;
      $display("[TB] FAIL rx_good_err_count: got %0d expected 0", n_rx_err - e0);
    end
    exp_b = exp_rx.pop_front();
    checks++;
    if (obs_rx.size() == 0) begin
      failures++;
      $display("[TB] FAIL rx_good_data: got nothing expected %h", exp_b);
    end else begin
      logic [7:0] got;
      got = obs_rx.pop_front();
      if (got !== exp_b) begin
        failures++;
        $display("[TB] FAIL rx_good_data: got %h expected %h", got, exp_b);
      end
    end
    last_rx = exp_b;
  endtask

  task automatic test_rx_bad_parity();
    int v0, e0, lf;
    v0 = n_rx_valid;
    e0 = n_rx_err;
    dev_send(make_frame(8'h1C, 1'b1), 11, lf);
    wait_cycles(5);
    checks++;
    if (n_rx_err - e0 !== 1) begin
      failures++;
      $display("[TB] FAIL rx_bad_err_count: got %0d expected 1", n_rx_err - e0);
    end
    checks++;
    if (n_rx_valid - v0 !== 0) begin
      failures++;
      $display("[TB] FAIL rx_bad_valid_count: got %0d expected 0", n_rx_valid - v0);
    end
    checks++;
    if (bus.rx_data !== last_rx) begin
      failures++;
      $display("[TB] FAIL rx_bad_data_held: got %h expected %h", bus.rx_data, last_rx);
    end
  endtask

  // The error pulse is registered one cycle after the counter expires.
  task automatic test_rx_timeout();
    int v0, lf, t_err;
    logic seen;
    v0 = n_rx_valid;
    seen = 1'b0;
    t_err = 0;
    dev_send(make_frame(8'h1C, 1'b0), 5, lf);
    for (int i = 0; i < TMO + 200 && !seen; i++) begin
      if (bus.rx_err === 1'b1) begin
        seen = 1'b1;
        t_err = cyc;
      end else begin
        wait_cycles(1);
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL rx_timeout_fired: got no rx_err expected pulse");
    end else if (t_err - lf !== TMO + 1 + FILT_LAT) begin
      failures++;
      $display("[TB] FAIL rx_timeout_latency: got %0d expected %0d", t_err - lf, TMO + 1 + FILT_LAT);
    end
    wait_cycles(2);
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rx_timeout_idle: got tx_ready=%b expected 1", bus.tx_ready);
    end
    checks++;
    if (n_rx_valid - v0 !== 0) begin
      failures++;
      $display("[TB] FAIL rx_timeout_valid: got %0d expected 0", n_rx_valid - v0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3];
    int lf;
    bytes[0] = 8'hA5;
    bytes[1] = 8'h01;
    bytes[2] = 8'hF0;
    foreach (bytes[i]) begin
      exp_rx.push_back(bytes[i]);
      dev_send(make_frame(bytes[i], good_parity(bytes[i])), 11, lf);
    end
    wait_cycles(5);
    while (exp_rx.size() > 0) begin
      logic [7:0] exp_b;
      exp_b = exp_rx.pop_front();
      checks++;
      if (obs_rx.size() == 0) begin
        failures++;
        $display("[TB] FAIL b2b_data: got nothing expected %h", exp_b);
      end else begin
        logic [7:0] got;
        got = obs_rx.pop_front();
        if (got !== exp_b) begin
          failures++;
          $display("[TB] FAIL b2b_data: got %h expected %h", got, exp_b);
        end
      end
      last_rx = exp_b;
    end
  endtask

  task automatic test_tx_ack();
    int d0, e0, inh;
    d0 = n_tx_done;
    e0 = n_tx_err;
    dev_bits.delete();
    push_tx_bits(8'hED);
    start_tx(8'hED);
    checks++;
    if ({bus.tx_ready, ps2_clk_q} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL tx_accept: got ready,clk_q=%b expected 01", {bus.tx_ready, ps2_clk_q});
    end
    dev_recv(1'b1, inh);
    wait_cycles(5);
    checks++;
    if (inh !== INH) begin
      failures++;
      $display("[TB] FAIL tx_inhibit_len: got %0d expected %0d", inh, INH);
    end
    for (int i = 0; i < PS2_FRAME_BITS; i++) begin
      checks++;
      if (dev_bits.size() == 0 || exp_bits.size() == 0) begin
        failures++;
        $display("[TB] FAIL tx_ack_bit%0d: got no sample expected one", i);
      end else begin
        logic got, exp_v;
        got = dev_bits.pop_front();
        exp_v = exp_bits.pop_front();
        if (got !== exp_v) begin
          failures++;
          $display("[TB] FAIL tx_ack_bit%0d: got %b expected %b", i, got, exp_v);
        end
      end
    end
    checks++;
    if (n_tx_done - d0 !== 1) begin
      failures++;
      $display("[TB] FAIL tx_ack_done: got %0d expected 1", n_tx_done - d0);
    end
    checks++;
    if (n_tx_err - e0 !== 0) begin
      failures++;
      $display("[TB] FAIL tx_ack_err: got %0d expected 0", n_tx_err - e0);
    end
  endtask

  task automatic test_tx_nack();
    int d0, e0, inh;
    d0 = n_tx_done;
    e0 = n_tx_err;
    dev_bits.delete();
    exp_bits.delete();
    push_tx_bits(8'hED);
    start_tx(8'hED);
    dev_recv(1'b0, inh);
    wait_cycles(5);
    for (int i = 0; i < PS2_FRAME_BITS; i++) begin
      checks++;
      if (dev_bits.size() == 0 || exp_bits.size() == 0) begin
        failures++;
        $display("[TB] FAIL tx_nack_bit%0d: got no sample expected one", i);
      end else begin
        logic got, exp_v;
        got = dev_bits.pop_front();
        exp_v = exp_bits.pop_front();
        if (got !== exp_v) begin
          failures++;
          $display("[TB] FAIL tx_nack_bit%0d: got %b expected %b", i, got, exp_v);
        end
      end
    end
    checks++;
    if (n_tx_err - e0 !== 1) begin
      failures++;
      $display("[TB] FAIL tx_nack_err: got %0d expected 1", n_tx_err - e0);
    end
    checks++;
    if (n_tx_done - d0 !== 0) begin
      failures++;
      $display("[TB] FAIL tx_nack_done: got %0d expected 0", n_tx_done - d0);
    end
  endtask

  task automatic test_reset_mid_tx();
    int d0, e0, guard;
    d0 = n_tx_done;
    e0 = n_tx_err;
    guard = 0;
    start_tx(8'h00);
    while (ps2_clk_q === 1'b1 && guard < INH + 100) begin
      wait_cycles(1);
      guard++;
    end
    wait_cycles(HALF);
    for (int k = 0; k < 3; k++) begin
      dev_clk = 1'b0;
      wait_cycles(HALF);
      dev_clk = 1'b1;
      wait_cycles(HALF);
    end
    rst = 1'b1;
    wait_cycles(1);
    checks++;
    if ({ps2_clk_q, ps2_data_q} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_mid_lines: got %b expected 00", {ps2_clk_q, ps2_data_q});
    end
    rst = 1'b0;
    wait_cycles(TMO + 100);
    checks++;
    if ((n_tx_done - d0) + (n_tx_err - e0) !== 0) begin
      failures++;
      $display("[TB] FAIL reset_mid_pulses: got %0d expected 0", (n_tx_done - d0) + (n_tx_err - e0));
    end
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_ready: got %b expected 1", bus.tx_ready);
    end
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset();
    test_rx_good();
    test_rx_bad_parity();
    test_rx_timeout();
    test_back_to_back();
    test_tx_ack();
    test_tx_nack();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
